// File: rtl/alu_regfile_pipe_pkg.sv
// Shared opcode encodings and flag bit positions for the ALU pipeline and its decoder.
package alu_regfile_pipe_pkg;

    localparam int OPCODE_WIDTH = 4;
    localparam int FLAGS_WIDTH  = 5;

    // Flag vector layout is {C,L,F,Z,N}
    localparam int FLAG_C = 4;
    localparam int FLAG_L = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_MOV = 4'd6,
        OP_LSH = 4'd7,
        OP_RSH = 4'd8,
        OP_CMP = 4'd9
    } alu_op_e;

endpackage

// File: rtl/alu_regfile_pipe_alu.sv
// Combinational ALU: result, flag vector and a flag-update enable (low for unknown opcodes).
module alu_core
    import alu_regfile_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [OPCODE_WIDTH-1:0] op_i,
    input  logic [DATA_WIDTH-1:0]   a_i,
    input  logic [DATA_WIDTH-1:0]   b_i,
    output logic [DATA_WIDTH-1:0]   result_o,
    output logic [FLAGS_WIDTH-1:0]  flags_o,
    output logic                    flags_upd_o
);
    localparam int SHW = $clog2(DATA_WIDTH);
    localparam int MSB = DATA_WIDTH - 1;

    logic [DATA_WIDTH:0]   sum_d;
    logic [DATA_WIDTH:0]   diff_d;
    logic                  ovf_add_d;
    logic                  ovf_sub_d;
    logic [SHW-1:0]        shamt_d;
    logic [DATA_WIDTH-1:0] res_d;
    logic                  c_d;
    logic                  l_d;
    logic                  f_d;

    // diff_d[DATA_WIDTH] is the borrow, i.e. A < B unsigned
    assign sum_d     = {1'b0, a_i} + {1'b0, b_i};
    assign diff_d    = {1'b0, a_i} - {1'b0, b_i};
    assign ovf_add_d = (a_i[MSB] == b_i[MSB]) && (sum_d[MSB] != a_i[MSB]);
    assign ovf_sub_d = (a_i[MSB] != b_i[MSB]) && (diff_d[MSB] != a_i[MSB]);
    assign shamt_d   = b_i[SHW-1:0];

    always_comb begin
        res_d       = '0;
        c_d         = 1'b0;
        l_d         = 1'b0;
        f_d         = 1'b0;
        flags_upd_o = 1'b1;
        case (op_i)
            OP_ADD: begin res_d = sum_d[MSB:0];  c_d = sum_d[DATA_WIDTH];  f_d = ovf_add_d; end
            OP_SUB: begin res_d = diff_d[MSB:0]; c_d = diff_d[DATA_WIDTH]; f_d = ovf_sub_d; end
            OP_AND: res_d = a_i & b_i;
            OP_OR:  res_d = a_i | b_i;
            OP_XOR: res_d = a_i ^ b_i;
            OP_NOT: res_d = ~a_i;
            OP_MOV: res_d = b_i;
            OP_LSH: res_d = a_i << shamt_d;
            OP_RSH: res_d = a_i >> shamt_d;
            OP_CMP: begin
                res_d = diff_d[MSB:0];
                c_d   = diff_d[DATA_WIDTH];
                l_d   = diff_d[DATA_WIDTH];
                f_d   = ovf_sub_d;
            end
            default: flags_upd_o = 1'b0;
        endcase
    end

    always_comb begin
        flags_o         = '0;
        flags_o[FLAG_C] = c_d;
        flags_o[FLAG_L] = l_d;
        flags_o[FLAG_F] = f_d;
        flags_o[FLAG_Z] = (res_d == '0);
        flags_o[FLAG_N] = res_d[MSB];
    end

    assign result_o = res_d;

endmodule

// File: rtl/alu_regfile_pipe.sv
// Two-stage EX/WB ALU pipeline with register file, WB-to-EX bypass and a debug read port.
module alu_regfile_pipe
    import alu_regfile_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 8,
    parameter int ZERO_R0    = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [$clog2(NUM_REGS)-1:0] a_reg,
    input  logic [$clog2(NUM_REGS)-1:0] b_reg,
    input  logic [$clog2(NUM_REGS)-1:0] dest_reg,
    input  logic [DATA_WIDTH-1:0]       immediate,
    input  logic                        immediate_p,
    input  logic                        write_en,
    input  logic [OPCODE_WIDTH-1:0]     alu_op,
    output logic [DATA_WIDTH-1:0]       result,
    output logic                        result_valid,
    output logic [FLAGS_WIDTH-1:0]      flags,
    input  logic [$clog2(NUM_REGS)-1:0] dbg_sel,
    output logic [DATA_WIDTH-1:0]       dbg_data
);
    localparam int IDXW = $clog2(NUM_REGS);

    logic [DATA_WIDTH-1:0]  regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]  result_q;
    logic                   result_valid_q;
    logic [FLAGS_WIDTH-1:0] flags_q;
    logic                   wb_we_q;
    logic [IDXW-1:0]        wb_dest_q;

    logic [DATA_WIDTH-1:0]  a_val_d;
    logic [DATA_WIDTH-1:0]  b_val_d;
    logic [DATA_WIDTH-1:0]  alu_res_d;
    logic [FLAGS_WIDTH-1:0] alu_flags_d;
    logic                   alu_upd_d;
    logic                   wb_we_d;

    // EX: operand read with WB bypass; the registered result doubles as WB data
    always_comb begin
        a_val_d = regs_q[a_reg];
        if (wb_we_q && (wb_dest_q == a_reg)) a_val_d = result_q;
        if ((ZERO_R0 != 0) && (a_reg == '0)) a_val_d = '0;

        b_val_d = regs_q[b_reg];
        if (wb_we_q && (wb_dest_q == b_reg)) b_val_d = result_q;
        if ((ZERO_R0 != 0) && (b_reg == '0)) b_val_d = '0;
        if (immediate_p) b_val_d = immediate;
    end

    alu_core #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .op_i        (alu_op),
        .a_i         (a_val_d),
        .b_i         (b_val_d),
        .result_o    (alu_res_d),
        .flags_o     (alu_flags_d),
        .flags_upd_o (alu_upd_d)
    );

    assign wb_we_d = in_valid && write_en && (alu_op != OP_CMP) &&
                     !((ZERO_R0 != 0) && (dest_reg == '0));

    // WB: latch EX outputs on accept, retire the previous op into the register file
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q       <= '0;
            result_valid_q <= 1'b0;
            flags_q        <= '0;
            wb_we_q        <= 1'b0;
            wb_dest_q      <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            result_valid_q <= in_valid;
            wb_we_q        <= wb_we_d;
            if (in_valid) begin
                result_q  <= alu_res_d;
                wb_dest_q <= dest_reg;
                if (alu_upd_d) flags_q <= alu_flags_d;
            end
            if (wb_we_q) regs_q[wb_dest_q] <= result_q;
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign flags        = flags_q;
    assign dbg_data     = ((ZERO_R0 != 0) && (dbg_sel == '0)) ? '0 : regs_q[dbg_sel];

endmodule

// File: tb/tb_alu_regfile_pipe.sv
// Directed bench for alu_regfile_pipe: default, ZERO_R0=1 and 32-bit/16-register instances.
module tb_alu_regfile_pipe;
    import alu_regfile_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        in_valid, immediate_p, write_en;
    logic [2:0]  a_reg, b_reg, dest_reg, dbg_sel;
    logic [15:0] immediate;
    logic [3:0]  alu_op;
    logic [15:0] res_a, dbg_a, res_z, dbg_z;
    logic        rv_a, rv_z;
    logic [4:0]  fl_a, fl_z;

    logic        x_in_valid, x_immp, x_we;
    logic [3:0]  x_a, x_b, x_dest, x_sel, x_op;
    logic [31:0] x_imm, x_res, x_dbg;
    logic        x_rv;
    logic [4:0]  x_fl;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_regfile_pipe #(.DATA_WIDTH(16), .NUM_REGS(8), .ZERO_R0(0)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .a_reg(a_reg), .b_reg(b_reg),
        .dest_reg(dest_reg), .immediate(immediate), .immediate_p(immediate_p),
        .write_en(write_en), .alu_op(alu_op), .result(res_a), .result_valid(rv_a),
        .flags(fl_a), .dbg_sel(dbg_sel), .dbg_data(dbg_a));

    alu_regfile_pipe #(.DATA_WIDTH(16), .NUM_REGS(8), .ZERO_R0(1)) dut_z (
        .clk(clk), .reset(reset), .in_valid(in_valid), .a_reg(a_reg), .b_reg(b_reg),
        .dest_reg(dest_reg), .immediate(immediate), .immediate_p(immediate_p),
        .write_en(write_en), .alu_op(alu_op), .result(res_z), .result_valid(rv_z),
        .flags(fl_z), .dbg_sel(dbg_sel), .dbg_data(dbg_z));

    alu_regfile_pipe #(.DATA_WIDTH(32), .NUM_REGS(16), .ZERO_R0(0)) dut_w (
        .clk(clk), .reset(reset), .in_valid(x_in_valid), .a_reg(x_a), .b_reg(x_b),
        .dest_reg(x_dest), .immediate(x_imm), .immediate_p(x_immp),
        .write_en(x_we), .alu_op(x_op), .result(x_res), .result_valid(x_rv),
        .flags(x_fl), .dbg_sel(x_sel), .dbg_data(x_dbg));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] d, input logic [15:0] imm, input logic ip,
                         input logic we);
        @(negedge clk);
        in_valid = 1'b1; alu_op = op; a_reg = a; b_reg = b; dest_reg = d;
        immediate = imm; immediate_p = ip; write_en = we;
        @(posedge clk); #1;
    endtask

    task automatic issue32(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] d, input logic [31:0] imm, input logic ip,
                           input logic we);
        @(negedge clk);
        x_in_valid = 1'b1; x_op = op; x_a = a; x_b = b; x_dest = d;
        x_imm = imm; x_immp = ip; x_we = we;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0; x_in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        in_valid = 0; immediate_p = 0; write_en = 0; a_reg = 0; b_reg = 0; dest_reg = 0;
        immediate = 0; alu_op = 0; dbg_sel = 3'd1;
        x_in_valid = 0; x_immp = 0; x_we = 0; x_a = 0; x_b = 0; x_dest = 0;
        x_imm = 0; x_op = 0; x_sel = 0;

        repeat (3) @(posedge clk); #1;
        chk("rst_result", 32'(res_a), 32'h0);
        chk("rst_valid", 32'(rv_a), 32'h0);
        chk("rst_flags", 32'(fl_a), 32'h0);
        chk("rst_dbg", 32'(dbg_a), 32'h0);
        chk("rst_result32", x_res, 32'h0);
        @(negedge clk); reset = 1'b0;

        // Reset lands between accept and WB edge: op is lost
        issue(OP_ADD, 3'd0, 3'd0, 3'd1, 16'd5, 1'b1, 1'b1);
        chk("midrst_pre_result", 32'(res_a), 32'h5);
        chk("midrst_pre_valid", 32'(rv_a), 32'h1);
        reset = 1'b1; #1;
        chk("midrst_dbg_r1", 32'(dbg_a), 32'h0);
        chk("midrst_valid", 32'(rv_a), 32'h0);
        chk("midrst_flags", 32'(fl_a), 32'h0);
        chk("midrst_result", 32'(res_a), 32'h0);
        in_valid = 1'b0;
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        chk("midrst_r1_after", 32'(dbg_a), 32'h0);

        // Back-to-back dependency through bypass
        issue(OP_MOV, 3'd0, 3'd0, 3'd2, 16'h1234, 1'b1, 1'b1);
        chk("mov_result", 32'(res_a), 32'h1234);
        issue(OP_ADD, 3'd2, 3'd2, 3'd3, 16'h0, 1'b0, 1'b1);
        chk("byp_result", 32'(res_a), 32'h2468);
        dbg_sel = 3'd3; #1;
        chk("byp_dbg_r3_early", 32'(dbg_a), 32'h0);
        idle();
        chk("byp_dbg_r3", 32'(dbg_a), 32'h2468);
        chk("idle_valid", 32'(rv_a), 32'h0);
        chk("idle_result_hold", 32'(res_a), 32'h2468);
        dbg_sel = 3'd2; #1;
        chk("byp_dbg_r2", 32'(dbg_a), 32'h1234);

        // Wrap and signed overflow
        issue(OP_MOV, 3'd0, 3'd0, 3'd1, 16'hFFFF, 1'b1, 1'b1);
        issue(OP_ADD, 3'd1, 3'd0, 3'd4, 16'h0001, 1'b1, 1'b1);
        chk("wrap_result", 32'(res_a), 32'h0);
        chk("wrap_flags", 32'(fl_a), 32'b10010);
        issue(OP_MOV, 3'd0, 3'd0, 3'd1, 16'h7FFF, 1'b1, 1'b1);
        issue(OP_ADD, 3'd1, 3'd0, 3'd4, 16'h0001, 1'b1, 1'b1);
        chk("ovf_result", 32'(res_a), 32'h8000);
        chk("ovf_flags", 32'(fl_a), 32'b00101);

        // CMP sets flags and never writes
        issue(OP_MOV, 3'd0, 3'd0, 3'd5, 16'hAAAA, 1'b1, 1'b1);
        issue(OP_MOV, 3'd0, 3'd0, 3'd1, 16'd3, 1'b1, 1'b1);
        issue(OP_MOV, 3'd0, 3'd0, 3'd2, 16'd7, 1'b1, 1'b1);
        issue(OP_CMP, 3'd1, 3'd2, 3'd5, 16'h0, 1'b0, 1'b1);
        chk("cmp_flags", 32'(fl_a), 32'b11001);
        idle(); idle();
        dbg_sel = 3'd5; #1;
        chk("cmp_dest_kept", 32'(dbg_a), 32'hAAAA);

        // Logic, subtract and shift ops against r6 = 0x00F0
        issue(OP_MOV, 3'd0, 3'd0, 3'd6, 16'h00F0, 1'b1, 1'b1);
        issue(OP_XOR, 3'd6, 3'd0, 3'd7, 16'h0FF0, 1'b1, 1'b1);
        chk("xor_result", 32'(res_a), 32'h0F00);
        chk("xor_flags", 32'(fl_a), 32'b00000);
        issue(OP_AND, 3'd6, 3'd0, 3'd7, 16'h0F0F, 1'b1, 1'b1);
        chk("and_result", 32'(res_a), 32'h0);
        chk("and_flags", 32'(fl_a), 32'b00010);
        issue(OP_SUB, 3'd6, 3'd0, 3'd7, 16'h00F1, 1'b1, 1'b1);
        chk("sub_result", 32'(res_a), 32'hFFFF);
        chk("sub_flags", 32'(fl_a), 32'b10001);
        issue(OP_RSH, 3'd6, 3'd0, 3'd7, 16'h0004, 1'b1, 1'b1);
        chk("rsh_result", 32'(res_a), 32'h000F);
        issue(OP_LSH, 3'd6, 3'd0, 3'd7, 16'h0014, 1'b1, 1'b1);
        chk("lsh_masked_result", 32'(res_a), 32'h0F00);
        issue(OP_OR, 3'd6, 3'd0, 3'd7, 16'h000F, 1'b1, 1'b1);
        chk("or_result", 32'(res_a), 32'h00FF);
        issue(OP_NOT, 3'd6, 3'd0, 3'd7, 16'h0, 1'b1, 1'b1);
        chk("not_result", 32'(res_a), 32'hFF0F);
        chk("not_flags", 32'(fl_a), 32'b00001);
        issue(4'hF, 3'd6, 3'd0, 3'd7, 16'h1234, 1'b1, 1'b1);
        chk("unk_result", 32'(res_a), 32'h0);
        chk("unk_flags_hold", 32'(fl_a), 32'b00001);
        issue(OP_MOV, 3'd0, 3'd0, 3'd6, 16'h8000, 1'b1, 1'b1);
        issue(OP_SUB, 3'd6, 3'd0, 3'd7, 16'h0001, 1'b1, 1'b1);
        chk("subovf_result", 32'(res_a), 32'h7FFF);
        chk("subovf_flags", 32'(fl_a), 32'b00100);
        idle();
        chk("idle_flags_hold", 32'(fl_a), 32'b00100);

        // ZERO_R0 instance drops r0 writes; default instance keeps them
        issue(OP_MOV, 3'd0, 3'd0, 3'd0, 16'd9, 1'b1, 1'b1);
        issue(OP_ADD, 3'd0, 3'd0, 3'd1, 16'd1, 1'b1, 1'b1);
        chk("z_result", 32'(res_z), 32'h1);
        chk("a_r0_result", 32'(res_a), 32'hA);
        idle();
        dbg_sel = 3'd0; #1;
        chk("z_dbg_r0", 32'(dbg_z), 32'h0);
        chk("a_dbg_r0", 32'(dbg_a), 32'h9);
        dbg_sel = 3'd1; #1;
        chk("z_dbg_r1", 32'(dbg_z), 32'h1);
        chk("a_dbg_r1", 32'(dbg_a), 32'hA);

        // 32-bit, 16-register instance
        issue32(OP_MOV, 4'd0, 4'd0, 4'd15, 32'd1, 1'b1, 1'b1);
        issue32(OP_LSH, 4'd15, 4'd0, 4'd14, 32'd31, 1'b1, 1'b1);
        chk("w_lsh_result", x_res, 32'h80000000);
        chk("w_lsh_flags", 32'(x_fl), 32'b00001);
        idle();
        x_sel = 4'd15; #1;
        chk("w_dbg_r15", x_dbg, 32'h1);
        x_sel = 4'd14; #1;
        chk("w_dbg_r14", x_dbg, 32'h80000000);
        issue32(OP_ADD, 4'd15, 4'd14, 4'd13, 32'h0, 1'b0, 1'b1);
        chk("w_add_result", x_res, 32'h80000001);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_regfile_pipe.md
ALU_REGFILE_PIPE -- requirements
Module: alu_regfile_pipe

Interface
REQ-001 Parameters SHALL be, one per line:
  DATA_WIDTH, 16, operand/result/register width (>=8)
  NUM_REGS, 8, register count (power of 2, >=2)
  ZERO_R0, 0, 1 = r0 reads as 0 and ignores writes
REQ-002 Ports SHALL be, one per line:
  clk  input  1  single clock, rising edge
  reset  input  1  asynchronous, active-high reset
  in_valid  input  1  operation presented this cycle
  a_reg  input  log2(NUM_REGS)  source A index
  b_reg  input  log2(NUM_REGS)  source B index
  dest_reg  input  log2(NUM_REGS)  destination index
  immediate  input  DATA_WIDTH  immediate operand
  immediate_p  input  1  1 = B operand is immediate
  write_en  input  1  1 = write result to dest_reg
  alu_op  input  OPCODE_WIDTH  operation code from shared package
  result  output  DATA_WIDTH  registered ALU result
  result_valid  output  1  result holds a newly accepted op
  flags  output  5  registered flags {C,L,F,Z,N}
  dbg_sel  input  log2(NUM_REGS)  debug read index
  dbg_data  output  DATA_WIDTH  architectural register value, no bypass
REQ-003 Clock and reset SHALL be named clk and reset; one clock; reset asynchronous and active-high.

Function
REQ-004 The block SHALL be a 2-stage pipeline: EX (read + ALU, combinational in the accept cycle), WB (registered result written to register file on the following edge).
REQ-005 Ops SHALL be ADD, SUB, AND, OR, XOR, NOT(A), MOV(B), LSH, RSH, CMP; unknown opcodes give result 0, flags unchanged.
REQ-006 Arithmetic SHALL wrap modulo 2^DATA_WIDTH; C = unsigned carry/borrow, F = signed overflow (ADD/SUB), Z = result (or A-B for CMP) zero, N = result MSB, L = A<B unsigned (CMP only).
REQ-007 LSH/RSH SHALL shift A logically by B[log2(DATA_WIDTH)-1:0]; shift >= DATA_WIDTH impossible by construction.
REQ-008 CMP SHALL update flags only; no register write regardless of write_en.
REQ-009 On an edge with in_valid=1: result, flags (per op) and WB stage (dest, data, write flag) SHALL load; result_valid=1 next cycle. With in_valid=0: result_valid=0, result and flags hold, WB write flag cleared.
REQ-010 Register file SHALL be written from WB one edge after acceptance; latency accept->architectural update = 2 edges.
REQ-011 Operand reads SHALL bypass from WB when WB write flag=1 and indices match (both A and B independently); immediate_p overrides B bypass.
REQ-012 Back-to-back dependent ops (every cycle in_valid=1) SHALL execute without stall; in_valid is always accepted.
REQ-013 With ZERO_R0=1, reads of r0 (including bypass) SHALL return 0 and writes to r0 SHALL be dropped.
REQ-014 dbg_data SHALL be combinational from architectural registers, excluding WB bypass.

Reset
REQ-015 Asserting reset SHALL immediately clear all registers, result, result_valid, flags and WB write flag to 0, including mid-pipeline; an op in WB at reset is lost.
REQ-016 First accepted op SHALL be the first edge after reset deassertion with in_valid=1.

Structure
REQ-017 Opcode encodings, OPCODE_WIDTH and flag bit positions SHALL live in a shared package used by this block and the decoder.
REQ-018 ALU SHALL be a combinational sub-module named alu_core (parameter DATA_WIDTH); register storage and bypass remain in alu_regfile_pipe.

Verification
REQ-019 Reset mid-op: ADD r1=imm 5, assert reset before WB edge -> dbg_data(r1)=0, result_valid=0, flags=0.
REQ-020 Bypass: MOV r2=imm 0x1234 then ADD r3=r2+r2 next cycle -> result 0x2468, r3=0x2468 two edges later.
REQ-021 Wrap/flags: r1=0xFFFF, ADD imm 1 -> result 0, C=1, Z=1, N=0, F=0; r1=0x7FFF ADD imm 1 -> 0x8000, F=1, N=1.
REQ-022 CMP: r1=3, r2=7, CMP r1,r2 with write_en=1 -> L=1, Z=0, dest unchanged.
REQ-023 ZERO_R0=1: MOV r0=imm 9 then ADD r1=r0+imm 1 -> r1=1, dbg_data(r0)=0.
REQ-024 Parameter sweep: DATA_WIDTH=32, NUM_REGS=16, LSH 1 by 31 -> 0x80000000; r15 writable/readable.
